// File: rtl/ev_seq_pkg.sv
// rtl/ev_seq_pkg.sv - shared types, opcode dispatch table and map functions for the EV op sequencer
package ev_seq_pkg;

    localparam int OPC_W    = 8;
    localparam int THREAD_W = 128;

    typedef enum logic [OPC_W-1:0] {
        OP_HALT         = 8'h00,
        OP_MULTIPLY_MAP = 8'h01
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_UNKNOWN = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [3:0][31:0] u32;
    } data_t;

    // The opcode stream and the thread's numeric view share the same bits.
    typedef union packed {
        logic [THREAD_W-1:0] opcodes;
        logic [3:0][31:0]    u32;
    } thread_t;

    typedef struct packed {
        data_t   data;
        thread_t thread;
    } ex_ev_t;

    typedef struct packed {
        logic       src_thread;
        logic       dst_thread;
        logic [5:0] n;
    } multiplyMap_a;

    function automatic int op_arg_bits(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_MULTIPLY_MAP: return $bits(multiplyMap_a);
            default:         return 0;
        endcase
    endfunction

    // dst[i] = dst[i] * src[i] for the first n lanes, 32-bit wrap.
    function automatic ex_ev_t multiplyMap_f(input ex_ev_t ev, input multiplyMap_a a);
        ex_ev_t      r;
        logic [31:0] s;
        logic [31:0] d;
        r = ev;
        for (int i = 0; i < 4; i++) begin
            s = a.src_thread ? ev.thread.u32[i] : ev.data.u32[i];
            d = a.dst_thread ? ev.thread.u32[i] : ev.data.u32[i];
            if (i < int'(a.n)) begin
                if (a.dst_thread) r.thread.u32[i] = d * s;
                else              r.data.u32[i]   = d * s;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ev_op_sequencer_if.sv
// rtl/ev_op_sequencer_if.sv - EV input/output handshake bundle for the op sequencer
interface ev_op_sequencer_if;
    import ev_seq_pkg::*;

    logic   in_valid;
    logic   in_ready;
    ex_ev_t in_ev;
    logic   out_valid;
    logic   out_ready;
    ex_ev_t out_ev;

    modport slave (
        input  in_valid, in_ev, out_ready,
        output in_ready, out_valid, out_ev
    );

    modport master (
        output in_valid, in_ev, out_ready,
        input  in_ready, out_valid, out_ev
    );
endinterface

// File: rtl/ev_op_dispatch.sv
// rtl/ev_op_dispatch.sv - decodes the head opcode, applies its map function and shifts the opcode stream
module ev_op_dispatch
    import ev_seq_pkg::*;
(
    input  ex_ev_t           ev_i,
    input  logic [OPC_W-1:0] hdr_i,
    output ex_ev_t           ev_o,
    output logic             known_o
);

    localparam int MM_ARG_W = $bits(multiplyMap_a);
    localparam int MM_SHIFT = OPC_W + op_arg_bits(OP_MULTIPLY_MAP);

    multiplyMap_a mm_args;
    assign mm_args = ev_i.thread.opcodes[THREAD_W-OPC_W-1 -: MM_ARG_W];

    // The shift is taken from the original stream so it overrides any op write into the thread.
    always_comb begin
        ev_o    = ev_i;
        known_o = 1'b0;
        case (hdr_i)
            OP_MULTIPLY_MAP: begin
                ev_o                = multiplyMap_f(ev_i, mm_args);
                ev_o.thread.opcodes = ev_i.thread.opcodes << MM_SHIFT;
                known_o             = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ev_op_sequencer.sv
// rtl/ev_op_sequencer.sv - iterative EV execute stage; EV_SEQ_SINGLE_STEP_EN adds a step input gating EXEC
module ev_op_sequencer
    import ev_seq_pkg::*;
#(
    parameter int MAX_OPS = 64,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef EV_SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    ev_op_sequencer_if.slave ev_if,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    state_e           state_q;
    ex_ev_t           ev_q;
    err_e             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    ex_ev_t           ev_d;
    logic             known;
    logic             step_ok;
    logic [OPC_W-1:0] hdr;

    assign hdr = ev_q.thread.opcodes[THREAD_W-1 -: OPC_W];

`ifdef EV_SEQ_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    ev_op_dispatch u_dispatch (
        .ev_i    (ev_q),
        .hdr_i   (hdr),
        .ev_o    (ev_d),
        .known_o (known)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ev_q        <= '0;
            err_q       <= ERR_NONE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_if.in_valid && in_ready_q) begin
                        ev_q       <= ev_if.in_ev;
                        cnt_q      <= '0;
                        err_q      <= ERR_NONE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (step_ok) begin
                        if (hdr == OP_HALT) begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (cnt_q == MAX_CNT) begin
                            err_q       <= ERR_TIMEOUT;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (known) begin
                            ev_q  <= ev_d;
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            err_q       <= ERR_UNKNOWN;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (ev_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ev_if.in_ready  = in_ready_q;
    assign ev_if.out_valid = out_valid_q;
    assign ev_if.out_ev    = ev_q;
    assign out_err         = err_q;
    assign op_count        = cnt_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_ev_op_sequencer.sv
// tb/tb_ev_op_sequencer.sv - randomized self-checking bench for ev_op_sequencer (default and MAX_OPS=2 builds)
module tb_ev_op_sequencer;
    import ev_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ev_op_sequencer_if m_if();
    ev_op_sequencer_if t_if();

    logic [1:0] m_err, t_err;
    logic [6:0] m_cnt, t_cnt;
    logic       m_busy, t_busy;
`ifdef EV_SEQ_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    ev_op_sequencer #(.MAX_OPS(64), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef EV_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .ev_if(m_if), .out_err(m_err), .op_count(m_cnt), .busy(m_busy)
    );

    ev_op_sequencer #(.MAX_OPS(2), .CNT_W(7)) dut_to (
        .clk(clk), .rst_n(rst_n),
`ifdef EV_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .ev_if(t_if), .out_err(t_err), .op_count(t_cnt), .busy(t_busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Program interpreter: byte stream at the top of the thread, 2 bytes per MULTIPLY_MAP.
    function automatic void model(input ex_ev_t ev, input int max_ops,
                                  output ex_ev_t res, output int err, output int cnt);
        logic [127:0] th;
        logic [31:0]  d[4];
        logic [31:0]  sv;
        logic [7:0]   hdr, a;
        th = ev.thread.opcodes;
        for (int i = 0; i < 4; i++) d[i] = ev.data.u32[i];
        err = 0;
        cnt = 0;
        for (int guard = 0; guard < 100; guard++) begin
            hdr = th[127:120];
            a   = th[119:112];
            if (hdr == 8'd0) break;
            if (cnt == max_ops) begin err = 2; break; end
            if (hdr != 8'd1) begin err = 1; break; end
            for (int i = 0; i < 4; i++) begin
                if (i < int'(a[5:0])) begin
                    sv = a[7] ? th[32*i +: 32] : d[i];
                    if (!a[6]) d[i] = d[i] * sv;
                end
            end
            th = th << 16;
            cnt++;
        end
        res.thread.opcodes = th;
        for (int i = 0; i < 4; i++) res.data.u32[i] = d[i];
    endfunction

    task automatic drive_in(input logic v, input ex_ev_t ev);
        m_if.in_valid = v; t_if.in_valid = v;
        m_if.in_ev    = ev; t_if.in_ev   = ev;
    endtask

    task automatic drive_ready(input logic r);
        m_if.out_ready = r;
        t_if.out_ready = r;
    endtask

    task automatic run_ev(input ex_ev_t ev, input int hold, input string tag);
        ex_ev_t m_ev, t_ev;
        int m_e, m_c, t_e, t_c;
        int lat, t_lat;
        model(ev, 64, m_ev, m_e, m_c);
        model(ev, 2, t_ev, t_e, t_c);
        drive_in(1'b1, ev);
        @(posedge clk); #1;
        drive_in(1'b0, '0);
        lat = 0;
        t_lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (t_if.out_valid && t_lat == 0) t_lat = c;
            if (m_if.out_valid && lat == 0) lat = c;
            if (lat != 0 && t_lat != 0) break;
        end
        chk({tag, " lat"}, lat, m_c + 1);
        chk({tag, " to_lat"}, t_lat, t_c + 1);
        chk({tag, " ev"}, m_if.out_ev, m_ev);
        chk({tag, " err"}, m_err, m_e);
        chk({tag, " cnt"}, m_cnt, m_c);
        chk({tag, " to_ev"}, t_if.out_ev, t_ev);
        chk({tag, " to_err"}, t_err, t_e);
        chk({tag, " to_cnt"}, t_cnt, t_c);
        chk({tag, " busy"}, m_busy, 1'b1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, m_if.out_valid, 1'b1);
            chk({tag, " hold_ev"}, m_if.out_ev, m_ev);
            chk({tag, " hold_rdy"}, m_if.in_ready, 1'b0);
        end
        drive_ready(1'b1);
        @(posedge clk); #1;
        drive_ready(1'b0);
        chk({tag, " idle_valid"}, m_if.out_valid, 1'b0);
        chk({tag, " idle_rdy"}, m_if.in_ready, 1'b1);
        chk({tag, " to_idle_rdy"}, t_if.in_ready, 1'b1);
        chk({tag, " idle_busy"}, m_busy, 1'b0);
    endtask

    function automatic ex_ev_t mk_ev(input logic [31:0] d0, input logic [31:0] d1,
                                     input logic [31:0] d2, input logic [31:0] d3,
                                     input logic [127:0] prog);
        ex_ev_t e;
        e.data.u32[0] = d0;
        e.data.u32[1] = d1;
        e.data.u32[2] = d2;
        e.data.u32[3] = d3;
        e.thread.opcodes = prog;
        return e;
    endfunction

    initial begin
        ex_ev_t       ev;
        logic [127:0] prog;
        int           nops;
        drive_in(1'b0, '0);
        drive_ready(1'b0);
        #12;
        chk("rst in_ready", m_if.in_ready, 1'b1);
        chk("rst out_valid", m_if.out_valid, 1'b0);
        chk("rst out_ev", m_if.out_ev, '0);
        chk("rst err", m_err, 2'd0);
        chk("rst cnt", m_cnt, 7'd0);
        chk("rst busy", m_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single op with 10 cycles of back-pressure
        ev = mk_ev(32'd10, 32'd11, 32'd12, 32'd13, {8'h01, 8'h02, 112'h0});
        run_ev(ev, 10, "single");
        chk("single d0", m_if.out_ev.data.u32[0], 32'd100);
        chk("single d1", m_if.out_ev.data.u32[1], 32'd121);
        chk("single d2", m_if.out_ev.data.u32[2], 32'd12);
        chk("single d3", m_if.out_ev.data.u32[3], 32'd13);
        chk("single cnt", m_cnt, 7'd1);
        chk("single err", m_err, 2'd0);

        ev = mk_ev(32'd3, 32'd5, 32'd6, 32'd7, {8'h01, 8'h01, 8'h01, 8'h01, 96'h0});
        run_ev(ev, 0, "chain");
        chk("chain d0", m_if.out_ev.data.u32[0], 32'd81);
        chk("chain cnt", m_cnt, 7'd2);

        ev = mk_ev(32'd1, 32'd2, 32'd3, 32'd4, {8'hFF, 8'h03, 112'h0});
        run_ev(ev, 1, "unknown");
        chk("unknown err", m_err, 2'd1);
        chk("unknown cnt", m_cnt, 7'd0);
        chk("unknown ev", m_if.out_ev, ev);

        ev = mk_ev(32'd3, 32'd0, 32'd0, 32'd0, {{3{8'h01, 8'h01}}, 80'h0});
        run_ev(ev, 0, "timeout");
        chk("timeout err", t_err, 2'd2);
        chk("timeout cnt", t_cnt, 7'd2);
        chk("timeout d0", t_if.out_ev.data.u32[0], 32'd81);
        chk("timeout main d0", m_if.out_ev.data.u32[0], 32'd6561);

        // reset during the second of three ops
        ev = mk_ev(32'd3, 32'd4, 32'd5, 32'd6, {{3{8'h01, 8'h04}}, 80'h0});
        drive_in(1'b1, ev);
        @(posedge clk); #1;
        drive_in(1'b0, '0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", m_if.out_valid, 1'b0);
        chk("midrst in_ready", m_if.in_ready, 1'b1);
        chk("midrst cnt", m_cnt, 7'd0);
        chk("midrst busy", m_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ev = mk_ev(32'd10, 32'd11, 32'd12, 32'd13, {8'h01, 8'h02, 112'h0});
        run_ev(ev, 0, "postrst");
        chk("postrst d0", m_if.out_ev.data.u32[0], 32'd100);

        for (int it = 0; it < 40; it++) begin
            prog = '0;
            nops = $urandom_range(0, 7);
            for (int k = 0; k < nops; k++) begin
                prog[127-16*k -: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'h01;
                prog[119-16*k -: 8] = 8'($urandom);
            end
            ev = mk_ev($urandom, $urandom, $urandom, $urandom, prog);
            run_ev(ev, $urandom_range(0, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ev_op_sequencer.md
Name: ev_op_sequencer

Overview:
- Iterative execute stage that sits directly upstream of, and drives, the combinational map units (multiplyMap_f and siblings).
- Accepts one ex_ev_t over a valid/ready handshake and holds it in a working register.
- Repeatedly decodes the instruction at the head of thread.opcodes, applies the selected map function, writes the result back, and shifts the opcode stream.
- Emits the final ex_ev_t downstream when HALT is reached or an error occurs.

Parameters:
- MAX_OPS, 64, maximum instructions executed per EV before a timeout error.
- OPC_W, 8, width of the opcode header at the head of thread.opcodes.
- CNT_W, 7, width of op_count; must satisfy 2**CNT_W > MAX_OPS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream EV valid
- in_ready  out  1  stage can accept an EV
- in_ev  in  $bits(ex_ev_t)  incoming execution vector
- out_valid  out  1  finished EV valid
- out_ready  in  1  downstream accepts EV
- out_ev  out  $bits(ex_ev_t)  finished execution vector
- out_err  out  2  error code: 0 none, 1 unknown opcode, 2 timeout
- op_count  out  CNT_W  instructions executed on the current EV
- busy  out  1  high in EXEC or DONE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_ev=0, out_err=0, op_count=0, busy=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: working reg <= in_ev, op_count <= 0, out_err <= 0, go to EXEC.
- EXEC (in_ready=0), decoding hdr = thread.opcodes[0:OPC_W-1] each cycle, in priority order:
  - hdr==OP_HALT (0): go to DONE.
  - op_count==MAX_OPS: out_err=2, go to DONE; the reg is not modified.
  - hdr is a known op: args = thread.opcodes[OPC_W : OPC_W+$bits(<op>_a)-1].
    - reg <= <op>_f(reg, args), with thread.opcodes then shifted left by OPC_W+$bits(<op>_a) bits and zero-filled.
    - op_count++, stay in EXEC.
  - Otherwise: out_err=1, go to DONE; the reg is not modified.
- Termination: zero-fill guarantees a HALT header is eventually reached.
- Thread overlap:
  - thread.opcodes overlaps thread.u32.
  - The shift is applied after the op result, so it overwrites any op write into the opcode region.
  - This is the defined behaviour.
- Latency: for k ops, out_valid rises k+1 cycles after the accept edge.
- DONE:
  - out_valid=1; out_ev, out_err and op_count are held stable.
  - On out_ready: go to IDLE. in_ready is not asserted in that same cycle; there is no bypass.
- Back-pressure: out_valid may remain high indefinitely; out_ev must not change while stalled.
- Reset mid-operation: everything returns to reset values immediately; the in-flight EV is discarded.
- Known ops: MULTIPLY_MAP (1). Further opcodes are added only through the package dispatch table.
- Arithmetic: whatever the map function defines (32-bit wrap for multiplyMap). The sequencer performs no arithmetic beyond op_count.

Optional Feature:
- Macro: EV_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - EXEC executes one instruction only in cycles with step==1 and holds otherwise.
  - The HALT, timeout and error decisions also wait for step.
- When undefined: the step port is absent and EXEC runs one instruction per cycle.

Decomposition:
- Shared package ev_seq_pkg:
  - opcode enum (OP_HALT=0, OP_MULTIPLY_MAP=1) and OPC_W.
  - function op_arg_bits(opcode).
  - error-code enum.
  - state enum.
- One natural sub-module, ev_op_dispatch (combinational):
  - Inputs: reg, hdr.
  - Outputs: next EV with opcodes already shifted, and a known flag.
  - Instantiates the map functions; the sequencer holds only the FSM and registers.

Test Plan:
- Single op: data.u32[0..3]=10,11,12,13; program MULTIPLY_MAP(data,data,2) then zeros. Required: out_valid 2 cycles after accept; data=100,121,12,13; op_count=1; out_err=0.
- Chained ops: two MULTIPLY_MAP(data,data,1) with data.u32[0]=3. Required: data.u32[0]=81; op_count=2; out_valid 3 cycles after accept.
- Unknown opcode: hdr=0xFF. Required: out_err=1; op_count=0; out_ev equals in_ev.
- Back-pressure: out_ready=0 for 10 cycles. Required: out_valid, out_ev and in_ready=0 stable; IDLE on the cycle after out_ready=1.
- Reset mid-EXEC: deassert rst_n during the second of three ops. Required: out_valid=0, in_ready=1, op_count=0 immediately; a new EV afterwards completes correctly.
- Timeout (MAX_OPS=2 override): three MULTIPLY_MAP ops. Required: out_err=2; op_count=2; third op not applied.
